// File: rtl/wishbone_bus_if.sv
// -----------------------------------------------------------------------------
// wishbone_bus_if
//
// Bridges one OpenMIPS memory-side port (ce/we/sel/addr/data) to a Wishbone
// B.3 classic master. One instance sits on the instruction side and one on
// the data side. While a transfer is in flight the pipeline is held through
// stallreq_o. When the slave acks while another stage is stalling the
// pipeline, the read data is parked in rd_buf until the stall clears.
//
// Optional feature (macro WB_TIMEOUT_EN):
//   When defined, a busy transfer with no ack for TIMEOUT_CYCLES cycles is
//   terminated as if acked with zero data, and bus_err_o pulses for one cycle.
//   When undefined, the block waits for ack indefinitely and bus_err_o is 0.
//
// Ports:
//   clk              system clock, all state on rising edge
//   rst              asynchronous active-low reset
//   stall_i[5:0]     pipeline stall vector from ctrl
//   flush_i          pipeline flush from ctrl
//   cpu_ce_i         CPU access request
//   cpu_data_i[31:0] CPU write data
//   cpu_addr_i[31:0] CPU byte address
//   cpu_we_i         1=write, 0=read
//   cpu_sel_i[3:0]   byte lane select
//   cpu_data_o[31:0] read data to CPU (combinational)
//   stallreq_o       stall request to ctrl (combinational)
//   wishbone_data_i  slave read data
//   wishbone_ack_i   slave acknowledge
//   wishbone_addr_o / data_o / we_o / sel_o / stb_o / cyc_o  registered bus
//   bus_err_o        one-cycle pulse after a timeout termination
// -----------------------------------------------------------------------------
module wishbone_bus_if #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_data_i,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_ack_i,
  output logic [31:0] wishbone_addr_o,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_we_o,
  output logic [3:0]  wishbone_sel_o,
  output logic        wishbone_stb_o,
  output logic        wishbone_cyc_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_BUSY,
    WB_WAIT_FOR_STALL
  } state_t;

  state_t      state;
  logic [31:0] rd_buf;
  logic        timeout_hit;

  // A timeout window shorter than one cycle is meaningless.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wishbone_bus_if: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 256) ? $clog2(TIMEOUT_CYCLES) : 8;

  logic [CNT_W-1:0] to_cnt;

  // The last permitted busy cycle: a real ack here still wins.
  assign timeout_hit = (state == WB_BUSY) && !wishbone_ack_i && !flush_i &&
                       (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt    <= '0;
      bus_err_o <= 1'b0;
    end else begin
      bus_err_o <= timeout_hit;
      // Counts only waiting busy cycles; anything that leaves WB_BUSY clears it.
      if (state == WB_BUSY && !wishbone_ack_i && !flush_i && !timeout_hit)
        to_cnt <= to_cnt + CNT_W'(1);
      else
        to_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_err_o   = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= WB_IDLE;
      rd_buf          <= '0;
      wishbone_addr_o <= '0;
      wishbone_data_o <= '0;
      wishbone_we_o   <= 1'b0;
      wishbone_sel_o  <= '0;
      wishbone_stb_o  <= 1'b0;
      wishbone_cyc_o  <= 1'b0;
    end else begin
      case (state)
        WB_IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            wishbone_cyc_o  <= 1'b1;
            wishbone_stb_o  <= 1'b1;
            wishbone_addr_o <= cpu_addr_i;
            wishbone_data_o <= cpu_data_i;
            wishbone_we_o   <= cpu_we_i;
            wishbone_sel_o  <= cpu_sel_i;
            rd_buf          <= '0;
            state           <= WB_BUSY;
          end
        end

        WB_BUSY: begin
          if (flush_i || wishbone_ack_i || timeout_hit) begin
            wishbone_cyc_o  <= 1'b0;
            wishbone_stb_o  <= 1'b0;
            wishbone_we_o   <= 1'b0;
            wishbone_addr_o <= '0;
            wishbone_data_o <= '0;
            wishbone_sel_o  <= '0;
          end

          if (flush_i) begin
            // Abort: an ack in the same cycle completes the bus transfer but
            // its data is dropped.
            rd_buf <= '0;
            state  <= WB_IDLE;
          end else if (wishbone_ack_i || timeout_hit) begin
            if (timeout_hit)
              rd_buf <= '0;
            else if (!cpu_we_i)
              rd_buf <= wishbone_data_i;
            state <= (stall_i != 6'b0) ? WB_WAIT_FOR_STALL : WB_IDLE;
          end
        end

        WB_WAIT_FOR_STALL: begin
          if (flush_i) begin
            rd_buf <= '0;
            state  <= WB_IDLE;
          end else if (stall_i == 6'b0) begin
            state <= WB_IDLE;
          end
        end

        default: state <= WB_IDLE;
      endcase
    end
  end

  // stallreq_o must react in the same cycle as the request/ack, so these two
  // outputs are decoded from the current state and inputs.
  // NOTE: every output gets a default before the case so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    if (rst) begin
      case (state)
        WB_IDLE: begin
          stallreq_o = cpu_ce_i && !flush_i;
        end
        WB_BUSY: begin
          if (!flush_i) begin
            if (wishbone_ack_i) begin
              if (!cpu_we_i)
                cpu_data_o = wishbone_data_i;
            end else if (!timeout_hit) begin
              stallreq_o = 1'b1;
            end
          end
        end
        WB_WAIT_FOR_STALL: begin
          cpu_data_o = rd_buf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/wishbone_bus_if.md
Name: wishbone_bus_if

Overview:
- Bridges one OpenMIPS memory-side port (ce/we/sel/addr/data, the pattern used for the instruction and data ports) to a Wishbone B.3 classic master.
- One instance goes on the instruction side and one on the data side, both between the core and the bus interconnect.
- Holds the pipeline through a stall request to ctrl until the slave acks.
- Honours pipeline flush and multi-stage stall.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in WB_BUSY without ack before forced termination. Used only with WB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- stall_i  input  6  pipeline stall vector from ctrl
- flush_i  input  1  pipeline flush from ctrl
- cpu_ce_i  input  1  CPU access request
- cpu_data_i  input  32  CPU write data
- cpu_addr_i  input  32  CPU byte address
- cpu_we_i  input  1  1=write, 0=read
- cpu_sel_i  input  4  byte lane select
- cpu_data_o  output  32  read data to CPU
- stallreq_o  output  1  stall request to ctrl
- wishbone_data_i  input  32  slave read data
- wishbone_ack_i  input  1  slave acknowledge
- wishbone_addr_o  output  32  bus address
- wishbone_data_o  output  32  bus write data
- wishbone_we_o  output  1  bus write enable
- wishbone_sel_o  output  4  bus byte select
- wishbone_stb_o  output  1  strobe
- wishbone_cyc_o  output  1  cycle valid
- bus_err_o  output  1  one-cycle pulse on timeout termination

Behaviour:
- Reset (rst=0, async):
  - state=WB_IDLE; rd_buf=0; timeout counter=0.
  - All wishbone_* outputs and bus_err_o are 0.
  - stallreq_o=0 and cpu_data_o=0 while reset is asserted.
- Registered outputs: wishbone_addr/data/we/sel/stb/cyc and bus_err_o.
- Combinational outputs: stallreq_o and cpu_data_o.
- WB_IDLE:
  - If cpu_ce_i=1 and flush_i=0: next edge registers cyc=stb=1 and copies addr/data/we/sel from the cpu_* inputs; go WB_BUSY; rd_buf=0.
  - Combinational: stallreq_o=1 in that same cycle; cpu_data_o=0.
  - Otherwise stay in WB_IDLE.
- WB_BUSY, no ack, no flush: hold all bus outputs; stallreq_o=1; cpu_data_o=0.
- WB_BUSY, ack=1, flush=0:
  - Next edge: cyc=stb=we=0; addr/data/sel=0.
  - If cpu_we_i=0: rd_buf=wishbone_data_i.
  - Next state is WB_WAIT_FOR_STALL if stall_i!=6'b0, else WB_IDLE.
  - Same cycle: stallreq_o=0; cpu_data_o=wishbone_data_i on read, 0 on write.
  - Bus latency is therefore 1 cycle minimum (ack in the cycle after stb rises) plus slave wait states.
- WB_BUSY, flush=1 (with or without ack):
  - Abort: next edge drops cyc/stb/we, clears addr/data/sel, rd_buf=0, go WB_IDLE.
  - stallreq_o=0; cpu_data_o=0.
  - If ack arrives in the same cycle, the bus transfer counts as complete and its data is discarded.
- WB_WAIT_FOR_STALL:
  - Covers the case where the pipeline is held by another stage after completion.
  - stallreq_o=0; cpu_data_o=rd_buf.
  - Go WB_IDLE when stall_i==0.
  - flush_i=1: go WB_IDLE, rd_buf=0.
  - No new bus cycle starts from this state.
- Never asserts stb without cyc. At most one outstanding transfer.
- cpu_* inputs are sampled only on the WB_IDLE→WB_BUSY edge; later changes are ignored until the transfer completes.
- Reset mid-transfer: cyc/stb drop immediately (async).

Optional Feature:
- WB_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter increments each WB_BUSY cycle without ack or flush; it clears on leaving WB_BUSY.
  - At count==TIMEOUT_CYCLES-1 with no ack: terminate exactly as an ack with wishbone_data_i treated as 32'h0 (rd_buf=0).
  - bus_err_o=1 for one cycle (registered, in the cycle after termination); stallreq_o=0 in the terminating cycle.
  - A real ack in the final cycle takes priority: normal completion, no error.
- WB_TIMEOUT_EN not defined: no counter; bus_err_o tied 0; the block waits for ack indefinitely.

Test Plan:
- Read, ack after 2 wait states, stall_i=0: addr 0x100, slave data 0xDEADBEEF:
  - stallreq_o high 3 cycles; cpu_data_o=0xDEADBEEF in the ack cycle.
  - cyc/stb low next edge; back to WB_IDLE.
- Write 0x12345678, sel=4'b0011, addr 0x204, ack next cycle:
  - wishbone_we_o=1, sel=0011, data=0x12345678 for one cycle; then all 0; cpu_data_o=0.
- Read ack with stall_i=6'b000011 held 3 cycles after ack, slave data 0xA5A5A5A5:
  - State WB_WAIT_FOR_STALL; cpu_data_o=0xA5A5A5A5 each cycle; stallreq_o=0; no new cyc.
  - Returns to WB_IDLE after stall_i=0.
- flush_i pulsed in the 2nd WB_BUSY cycle, then ack and flush together on a second transfer:
  - Both abort to WB_IDLE; rd_buf=0; stallreq_o=0 in the flush cycle.
- rst low for 1 cycle mid-WB_BUSY:
  - cyc/stb/stallreq_o fall without a clock edge; state=WB_IDLE after release.
- WB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack:
  - Termination after 4 WB_BUSY cycles; cpu_data_o=0; bus_err_o 1-cycle pulse.
  - Without the macro: stallreq_o stays high for 300 cycles.
